// File: rtl/hex_display_scan_if.sv
// Signal bundle between the MMIO hex register and the seven-segment scanner.
// master: the side that owns the hex value and brightness setting.
// slave: the scanner that drives the physical display pins.
interface hex_display_scan_if;
    logic [15:0] hex;
    logic [1:0]  dim;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output hex,
        output dim,
        input  an,
        input  seg,
        input  dp,
        input  frame_tick
    );

    modport slave (
        input  hex,
        input  dim,
        output an,
        output seg,
        output dp,
        output frame_tick
    );
endinterface

// File: rtl/hex_display_scan.sv
// Four-digit common-anode seven-segment scanner.
// The display value is latched once per frame so that a frame never mixes
// digits from two different values. Leading zeros can be blanked, and each
// digit slot is duty-cycled to give four brightness levels.
module hex_display_scan #(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    hex_display_scan_if.slave bus
);

    localparam int unsigned      PW         = $clog2(REFRESH_DIV);
    localparam int unsigned      DW         = PW + 2;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0]    QUARTER    = DW'(REFRESH_DIV / 4);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_tick_q, frame_tick_d;

    logic          terminal;
    logic [3:0]    nib;
    logic          blank;
    logic          lit;
    logic [DW-1:0] threshold;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Prescaler, digit index and frame-synchronous shadow reload.
    always_comb begin
        terminal     = (presc_q == PRESC_LAST);
        presc_d      = terminal ? '0 : presc_q + 1'b1;
        idx_d        = terminal ? idx_q + 2'd1 : idx_q;
        shadow_d     = (terminal && (idx_q == 2'd3)) ? bus.hex : shadow_q;
        // Registered so the pulse is high exactly while the state sits on the
        // frame's terminal count, i.e. the cycle whose closing edge reloads shadow.
        frame_tick_d = (presc_d == PRESC_LAST) && (idx_d == 2'd3);
    end

    // Digit selection, leading-zero blanking, duty cycle and segment decode.
    always_comb begin
        nib = shadow_q[{idx_q, 2'b00} +: 4];

        blank = 1'b0;
        if (BLANK_LEADING) begin
            case (idx_q)
                2'd1:    blank = (shadow_q[15:4]  == 12'h000);
                2'd2:    blank = (shadow_q[15:8]  == 8'h00);
                2'd3:    blank = (shadow_q[15:12] == 4'h0);
                default: blank = 1'b0;
            endcase
        end

        // (dim+1)*REFRESH_DIV/4 computed as (dim+1)*(REFRESH_DIV/4): exact because
        // REFRESH_DIV is a multiple of 4, and it never exceeds REFRESH_DIV, so it
        // fits the widened compare even when REFRESH_DIV is a power of two.
        threshold = (DW'(bus.dim) + DW'(1)) * QUARTER;
        lit       = (DW'(presc_q) < threshold);

        if (lit && !blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = decode(nib);
        end else begin
            an_d  = 4'b1111;
            seg_d = 7'h7F;
        end
    end

    // State and output registers, asynchronously cleared to a dark display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            an_q         <= '1;
            seg_q        <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: two instances (leading-zero blanking on/off)
// compared every cycle against a cycle-count based model, plus directed
// literal expectations for scan order, tear-free update, blanking,
// brightness and asynchronous reset.
module tb_hex_display_scan;

    localparam int unsigned D     = 8;
    localparam int unsigned FRAME = 4 * D;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] hex   = 16'h1234;
    logic [1:0]  dim   = 2'd3;

    int errors = 0;
    int checks = 0;

    hex_display_scan_if bus0 ();
    hex_display_scan_if bus1 ();

    assign bus0.hex = hex;
    assign bus0.dim = dim;
    assign bus1.hex = hex;
    assign bus1.dim = dim;

    hex_display_scan #(.REFRESH_DIV(D), .BLANK_LEADING(1'b1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    hex_display_scan #(.REFRESH_DIV(D), .BLANK_LEADING(1'b0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // c = cycles elapsed since reset release; the slot position, digit and
    // frame follow directly from it.
    function automatic bit model_on(input int unsigned c, input logic [15:0] sh,
                                    input logic [1:0] dm, input bit bl);
        int unsigned pos   = c % D;
        int unsigned dig   = (c / D) % 4;
        bit          bright = (pos * 4) < ((int'(dm) + 1) * D);
        bit          dark  = bl && (dig != 0) && ((sh >> (4 * dig)) == 16'd0);
        return bright && !dark;
    endfunction

    function automatic logic [3:0] model_an(input int unsigned c, input logic [15:0] sh,
                                            input logic [1:0] dm, input bit bl);
        int unsigned dig = (c / D) % 4;
        return model_on(c, sh, dm, bl) ? (4'hF ^ (4'd1 << dig)) : 4'hF;
    endfunction

    function automatic logic [6:0] model_seg(input int unsigned c, input logic [15:0] sh,
                                             input logic [1:0] dm, input bit bl);
        int unsigned dig = (c / D) % 4;
        int unsigned v   = (sh >> (4 * dig)) & 16'hF;
        return model_on(c, sh, dm, bl) ? SEG_TBL[v] : 7'h7F;
    endfunction

    int unsigned cyc      = 0;
    logic [15:0] m_shadow = 16'h0;
    logic [3:0]  e_an0    = 4'hF;
    logic [3:0]  e_an1    = 4'hF;
    logic [6:0]  e_seg0   = 7'h7F;
    logic [6:0]  e_seg1   = 7'h7F;
    logic        e_tick   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      = 0;
            m_shadow = 16'h0;
            e_an0    = 4'hF;
            e_an1    = 4'hF;
            e_seg0   = 7'h7F;
            e_seg1   = 7'h7F;
            e_tick   = 1'b0;
        end else begin
            e_an0  = model_an (cyc, m_shadow, dim, 1'b1);
            e_seg0 = model_seg(cyc, m_shadow, dim, 1'b1);
            e_an1  = model_an (cyc, m_shadow, dim, 1'b0);
            e_seg1 = model_seg(cyc, m_shadow, dim, 1'b0);
            if ((cyc % FRAME) == FRAME - 1)
                m_shadow = hex;
            cyc++;
            e_tick = ((cyc % FRAME) == FRAME - 1);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("an0",     bus0.an,  e_an0);
        check("seg0",    bus0.seg, e_seg0);
        check("an1",     bus1.an,  e_an1);
        check("seg1",    bus1.seg, e_seg1);
        check("tick0",   bus0.frame_tick, e_tick);
        check("tick1",   bus1.frame_tick, e_tick);
        check("dp0",     bus0.dp, 1'b1);
        check("dp1",     bus1.dp, 1'b1);
        check("onehot0", ($countones(~bus0.an) > 1), 1'b0);
        check("onehot1", ($countones(~bus1.an) > 1), 1'b0);
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        int n = 0;
        step(1);
        while (bus0.frame_tick !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        check("tick_seen", bus0.frame_tick, 1'b1);
    endtask

    // Waits for a frame boundary, then checks mid-slot of each digit of the
    // frame that follows. Vectors are packed digit3..digit0.
    task automatic show_frame(input logic [15:0] an0v, input logic [27:0] seg0v,
                              input logic [15:0] an1v, input logic [27:0] seg1v);
        wait_tick();
        step(1);
        for (int d = 0; d < 4; d++) begin
            step(4);
            check("frame_an0",  bus0.an,  an0v[4*d +: 4]);
            check("frame_seg0", bus0.seg, seg0v[7*d +: 7]);
            check("frame_an1",  bus1.an,  an1v[4*d +: 4]);
            check("frame_seg1", bus1.seg, seg1v[7*d +: 7]);
            step(4);
        end
    endtask

    initial begin
        int n;

        // 1. reset and first frame
        #1 rst_n = 1'b0;
        step(2);
        check("rst_an",   bus0.an, 4'hF);
        check("rst_seg",  bus0.seg, 7'h7F);
        check("rst_tick", bus0.frame_tick, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("first_an",  bus0.an, 4'hE);
            check("first_seg", bus0.seg, 7'h40);
        end
        step(1);
        check("first_blank_an", bus0.an, 4'hF);

        // frame period
        wait_tick();
        n = 0;
        do begin
            step(1);
            n++;
        end while (bus0.frame_tick !== 1'b1 && n < 100);
        check("frame_period", n, FRAME);

        // 2. scan order for 1234
        show_frame({4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h24, 7'h30, 7'h19},
                   {4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h24, 7'h30, 7'h19});

        // 3. tear-free update during the idx=1 slot
        wait_tick();
        step(12);
        hex = 16'hABCD;
        step(9);
        check("tear_an2",  bus0.an, 4'hB);
        check("tear_seg2", bus0.seg, 7'h24);
        step(8);
        check("tear_an3",  bus0.an, 4'h7);
        check("tear_seg3", bus0.seg, 7'h79);
        show_frame({4'h7, 4'hB, 4'hD, 4'hE}, {7'h08, 7'h03, 7'h46, 7'h21},
                   {4'h7, 4'hB, 4'hD, 4'hE}, {7'h08, 7'h03, 7'h46, 7'h21});

        // 4. leading-zero blanking
        hex = 16'h00F0;
        show_frame({4'hF, 4'hF, 4'hD, 4'hE}, {7'h7F, 7'h7F, 7'h0E, 7'h40},
                   {4'h7, 4'hB, 4'hD, 4'hE}, {7'h40, 7'h40, 7'h0E, 7'h40});

        // 5. brightness
        dim = 2'd0;
        wait_tick();
        step(1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("dim0_an", bus0.an, (i < 2) ? 4'hE : 4'hF);
        end
        dim = 2'd2;
        wait_tick();
        step(1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("dim2_an", bus0.an, (i < 6) ? 4'hE : 4'hF);
        end

        // 6. asynchronous reset during the idx=2 slot
        hex = 16'h1234;
        dim = 2'd3;
        wait_tick();
        step(20);
        check("pre_async_an", bus0.an, 4'hB);
        #2 rst_n = 1'b0;
        #1;
        check("async_an0",   bus0.an, 4'hF);
        check("async_seg0",  bus0.seg, 7'h7F);
        check("async_tick0", bus0.frame_tick, 1'b0);
        check("async_an1",   bus1.an, 4'hF);
        check("async_seg1",  bus1.seg, 7'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("restart_an",  bus0.an, 4'hE);
            check("restart_seg", bus0.seg, 7'h40);
        end
        step(1);
        check("restart_blank_an0", bus0.an, 4'hF);
        check("restart_an1",       bus1.an, 4'hD);
        check("restart_seg1",      bus1.seg, 7'h40);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
